// File: rtl/bus_pkg.sv
// Shared types and constants for the bus response controller.
package bus_pkg;

  // Transaction sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Number of decoded targets and bit positions inside the select/strobe vectors.
  localparam int NUM_TGT   = 7;
  localparam int TGT_ROM   = 0;
  localparam int TGT_RAM   = 1;
  localparam int TGT_IO    = 2;
  localparam int TGT_GFX   = 3;
  localparam int TGT_KBD   = 4;
  localparam int TGT_UART  = 5;
  localparam int TGT_ACCEL = 6;

  // Wait-state counter width and default timing.
  localparam int CNT_W           = 8;
  localparam int DEF_ROM_WAIT    = 1;
  localparam int DEF_PERIPH_WAIT = 2;
  localparam int DEF_TIMEOUT     = 255;

  // Data returned to the core on a failed transfer.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // True when exactly one select line is set.
  function automatic logic is_onehot(input logic [NUM_TGT-1:0] v);
    return (v != '0) && ((v & (v - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Saturating wait-state counter with clear, enable and an equality match flag.
module bus_wait_counter
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] match_value,
  output logic             match
);

  logic [CNT_W-1:0] count;

  // Count up while enabled, hold at all-ones, and restart from zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign match = (count == match_value);

endmodule

// File: rtl/bus_response_controller.sv
// Sequences one bus transaction at a time from the decoder selects to the core.
module bus_response_controller
  import bus_pkg::*;
#(
  parameter int ROM_WAIT    = DEF_ROM_WAIT,
  parameter int PERIPH_WAIT = DEF_PERIPH_WAIT,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        rom_sel,
  input  logic        ram_sel,
  input  logic        io_sel,
  input  logic        gfx_sel,
  input  logic        kbd_sel,
  input  logic        uart_sel,
  input  logic        accel_sel,
  input  logic [31:0] rom_rdata,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] io_rdata,
  input  logic [31:0] gfx_rdata,
  input  logic [31:0] kbd_rdata,
  input  logic [31:0] uart_rdata,
  input  logic [31:0] accel_rdata,
  input  logic        ram_ack,
  input  logic        gfx_ack,
  input  logic        accel_ack,
  output logic [6:0]  dev_strobe,
  output logic        dev_we,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        bus_err
);

  state_t             state;
  logic [NUM_TGT-1:0] sel_vec;
  logic [NUM_TGT-1:0] tgt;
  logic               we_q;
  logic               fixed_tgt;
  logic               acked_tgt;
  logic               got_ack;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_match;
  logic [CNT_W-1:0]   match_value;
  logic               access_done;
  logic               access_err;
  logic [31:0]        rdata_sel;

  assign sel_vec = {accel_sel, uart_sel, kbd_sel, gfx_sel, io_sel, ram_sel, rom_sel};

  assign fixed_tgt = tgt[TGT_ROM] | tgt[TGT_IO] | tgt[TGT_KBD] | tgt[TGT_UART];
  assign acked_tgt = tgt[TGT_RAM] | tgt[TGT_GFX] | tgt[TGT_ACCEL];

  // Only the acknowledge of the latched target can end the access.
  assign got_ack = (tgt[TGT_RAM] & ram_ack) | (tgt[TGT_GFX] & gfx_ack) |
                   (tgt[TGT_ACCEL] & accel_ack);

  // The counter restarts whenever the bus is idle and runs through the access phase.
  assign cnt_clear  = (state == IDLE);
  assign cnt_enable = (state == ACCESS);

  // Pick the count that ends the access: a fixed wait, or the timeout for acked targets.
  always_comb begin
    match_value = CNT_W'(TIMEOUT);
    if (tgt[TGT_ROM]) begin
      match_value = CNT_W'(ROM_WAIT);
    end else if (tgt[TGT_IO] | tgt[TGT_KBD] | tgt[TGT_UART]) begin
      match_value = CNT_W'(PERIPH_WAIT);
    end
  end

  bus_wait_counter u_wait_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .match_value (match_value),
    .match       (cnt_match)
  );

  // Decide whether this access cycle is the last one and whether it failed; ack beats timeout.
  always_comb begin
    access_done = 1'b0;
    access_err  = 1'b0;
    if (acked_tgt) begin
      if (got_ack) begin
        access_done = 1'b1;
      end else if (cnt_match) begin
        access_done = 1'b1;
        access_err  = 1'b1;
      end
    end else if (fixed_tgt && cnt_match) begin
      access_done = 1'b1;
    end
  end

  // Route the latched target's read data toward the core.
  always_comb begin
    rdata_sel = ERR_RDATA;
    case (1'b1)
      tgt[TGT_ROM]:   rdata_sel = rom_rdata;
      tgt[TGT_RAM]:   rdata_sel = ram_rdata;
      tgt[TGT_IO]:    rdata_sel = io_rdata;
      tgt[TGT_GFX]:   rdata_sel = gfx_rdata;
      tgt[TGT_KBD]:   rdata_sel = kbd_rdata;
      tgt[TGT_UART]:  rdata_sel = uart_rdata;
      tgt[TGT_ACCEL]: rdata_sel = accel_rdata;
      default:        rdata_sel = ERR_RDATA;
    endcase
  end

  // Transaction FSM with registered strobe, write enable, ready, error and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt        <= '0;
      we_q       <= 1'b0;
      dev_strobe <= '0;
      dev_we     <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            tgt  <= sel_vec;
            we_q <= cpu_we;
            if (is_onehot(sel_vec)) begin
              state      <= ACCESS;
              dev_strobe <= sel_vec;
              dev_we     <= cpu_we;
            end else begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              bus_err   <= 1'b1;
              cpu_rdata <= ERR_RDATA;
            end
          end
        end
        ACCESS: begin
          if (access_done) begin
            state      <= RESP;
            dev_strobe <= '0;
            dev_we     <= 1'b0;
            cpu_ready  <= 1'b1;
            bus_err    <= access_err;
            if (access_err) begin
              cpu_rdata <= ERR_RDATA;
            end else if (!we_q) begin
              cpu_rdata <= rdata_sel;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          dev_strobe <= '0;
          dev_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule
